// File: rtl/demux2_stream_pkg.sv
// Shared types and constants for the 1:2 stream demultiplexer.
package demux2_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_t;

  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;
  localparam int   CNT_W = 16;
endpackage

// File: rtl/demux2_stream_if.sv
// Producer plus two-sink handshake bundle for demux2_stream.
interface demux2_stream_if #(parameter int n = 16);
  logic [n-1:0] in_data;
  logic         in_valid;
  logic         select;
  logic         in_ready;
  logic [n-1:0] a_data;
  logic         a_valid;
  logic         a_ready;
  logic [n-1:0] b_data;
  logic         b_valid;
  logic         b_ready;

  modport slave (
    input  in_data, in_valid, select, a_ready, b_ready,
    output in_ready, a_data, a_valid, b_data, b_valid
  );
  modport master (
    output in_data, in_valid, select, a_ready, b_ready,
    input  in_ready, a_data, a_valid, b_data, b_valid
  );
endinterface

// File: rtl/demux2_obuf.sv
// Two-entry registered skid buffer; valid/full are flopped from the next state.
// DEMUX2_STREAM_COUNT_EN adds a wrapping pop counter.
module demux2_obuf
  import demux2_pkg::*;
#(
  parameter int n = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [n-1:0]     din,
  output logic             vld,
  input  logic             rdy,
  output logic [n-1:0]     dout,
  output logic             full
`ifdef DEMUX2_STREAM_COUNT_EN
  ,
  output logic [CNT_W-1:0] cnt
`endif
);
  buf_state_t   st, st_d;
  logic [n-1:0] head, tail, head_d, tail_d;
  logic         pop;

  assign pop  = vld && rdy;
  assign dout = head;

  always_comb begin
    st_d   = st;
    head_d = head;
    tail_d = tail;
    case (st)
      EMPTY: if (push) begin
        st_d   = ONE;
        head_d = din;
      end
      ONE: begin
        if (push && pop) head_d = din;
        else if (push) begin
          st_d   = TWO;
          tail_d = din;
        end else if (pop) st_d = EMPTY;
      end
      // Upstream cannot push while full, so only a pop moves TWO.
      TWO: if (pop) begin
        st_d   = ONE;
        head_d = tail;
      end
      default: st_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= EMPTY;
      head <= '0;
      tail <= '0;
      vld  <= 1'b0;
      full <= 1'b0;
    end else begin
      st   <= st_d;
      head <= head_d;
      tail <= tail_d;
      vld  <= (st_d != EMPTY);
      full <= (st_d == TWO);
    end
  end

`ifdef DEMUX2_STREAM_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (pop) cnt <= cnt + 1'b1;
  end
`endif
endmodule

// File: rtl/demux2_stream.sv
// 1:2 stream demux: select steering and in_ready mux over two skid buffers.
// DEMUX2_STREAM_COUNT_EN exposes per-output pop counts.
module demux2_stream
  import demux2_pkg::*;
#(
  parameter int n = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  demux2_stream_if.slave   bus
`ifdef DEMUX2_STREAM_COUNT_EN
  ,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
`endif
);
  // Lane index equals the select code: lane SEL_A is A, lane SEL_B is B.
  logic [1:0]        push, full, vld, rdy;
  logic [1:0][n-1:0] dat;
  logic              in_rdy;
`ifdef DEMUX2_STREAM_COUNT_EN
  logic [1:0][CNT_W-1:0] cnt;
`endif

  assign in_rdy      = !full[bus.select];
  assign bus.in_ready = in_rdy;
  assign rdy[SEL_A]  = bus.a_ready;
  assign rdy[SEL_B]  = bus.b_ready;

  for (genvar i = 0; i < 2; i++) begin : g_buf
    assign push[i] = bus.in_valid && in_rdy && (bus.select == 1'(i));
    demux2_obuf #(.n(n)) u_buf (
      .clk  (clk),
      .rst_n(rst_n),
      .push (push[i]),
      .din  (bus.in_data),
      .vld  (vld[i]),
      .rdy  (rdy[i]),
      .dout (dat[i]),
      .full (full[i])
`ifdef DEMUX2_STREAM_COUNT_EN
      ,
      .cnt  (cnt[i])
`endif
    );
  end

  assign bus.a_valid = vld[SEL_A];
  assign bus.a_data  = dat[SEL_A];
  assign bus.b_valid = vld[SEL_B];
  assign bus.b_data  = dat[SEL_B];

`ifdef DEMUX2_STREAM_COUNT_EN
  assign a_count = cnt[SEL_A];
  assign b_count = cnt[SEL_B];
`endif
endmodule

// File: tb/tb_demux2_stream.sv
// Bench for demux2_stream: directed vector table, corner sequences and a
// queue-based random reference model.
module tb_demux2_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux2_stream_if #(.n(16)) bus();
`ifdef DEMUX2_STREAM_COUNT_EN
  logic [15:0] a_count, b_count;
`endif

  demux2_stream #(.n(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef DEMUX2_STREAM_COUNT_EN
    ,
    .a_count(a_count),
    .b_count(b_count)
`endif
  );

  int npass = 0;
  int ntot  = 0;

  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [15:0] ca = 16'h0;
  logic [15:0] cb = 16'h0;

  typedef struct {
    logic iv; logic sel; logic [15:0] d; logic ar; logic br;
    logic e_ir; logic e_av; logic [15:0] e_ad; logic e_bv; logic [15:0] e_bd;
  } vec_t;
  vec_t tbl[14];

  task automatic chkb(input string nm, input logic act, input logic exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
  endtask

  task automatic chkw(input string nm, input logic [15:0] act, input logic [15:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  task automatic drive(input logic iv, input logic sel, input logic [15:0] d,
                       input logic ar, input logic br);
    bus.in_valid = iv;
    bus.select   = sel;
    bus.in_data  = d;
    bus.a_ready  = ar;
    bus.b_ready  = br;
  endtask

  // Reference model at the clock edge: sinks drain first, then the word is
  // accepted if its destination queue had room before the edge.
  task automatic model_edge();
    bit room, pa, pb;
    room = bus.select ? (qa.size() < 2) : (qb.size() < 2);
    pa = (qa.size() != 0) && bus.a_ready;
    pb = (qb.size() != 0) && bus.b_ready;
    if (pa) begin void'(qa.pop_front()); ca = ca + 16'h1; end
    if (pb) begin void'(qb.pop_front()); cb = cb + 16'h1; end
    if (bus.in_valid && room) begin
      if (bus.select) qa.push_back(bus.in_data);
      else            qb.push_back(bus.in_data);
    end
  endtask

  task automatic check_model();
    chkb("rnd a_valid", bus.a_valid, qa.size() != 0);
    chkb("rnd b_valid", bus.b_valid, qb.size() != 0);
    if (qa.size() != 0) chkw("rnd a_data", bus.a_data, qa[0]);
    if (qb.size() != 0) chkw("rnd b_data", bus.b_data, qb[0]);
`ifdef DEMUX2_STREAM_COUNT_EN
    chkw("rnd a_count", a_count, ca);
    chkw("rnd b_count", b_count, cb);
`endif
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 16'hDEAD, 1'b1, 1'b1);
    #1;
    chkb({tag, " a_valid"}, bus.a_valid, 1'b0);
    chkb({tag, " b_valid"}, bus.b_valid, 1'b0);
    chkw({tag, " a_data"}, bus.a_data, 16'h0);
    chkw({tag, " b_data"}, bus.b_data, 16'h0);
    chkb({tag, " in_ready"}, bus.in_ready, 1'b1);
`ifdef DEMUX2_STREAM_COUNT_EN
    chkw({tag, " a_count"}, a_count, 16'h0);
    chkw({tag, " b_count"}, b_count, 16'h0);
`endif
    @(posedge clk); #1;
    chkb({tag, " held a_valid"}, bus.a_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chkb({tag, " post a_valid"}, bus.a_valid, 1'b0);
    chkb({tag, " post b_valid"}, bus.b_valid, 1'b0);
    qa.delete(); qb.delete();
    ca = 16'h0; cb = 16'h0;
  endtask

  task automatic step(input vec_t v, input int idx);
    string s;
    s = $sformatf("vec%0d", idx);
    @(negedge clk);
    drive(v.iv, v.sel, v.d, v.ar, v.br);
    #1;
    chkb({s, " in_ready"}, bus.in_ready, v.e_ir);
    @(posedge clk); #1;
    chkb({s, " a_valid"}, bus.a_valid, v.e_av);
    chkb({s, " b_valid"}, bus.b_valid, v.e_bv);
    if (v.e_av) chkw({s, " a_data"}, bus.a_data, v.e_ad);
    if (v.e_bv) chkw({s, " b_data"}, bus.b_data, v.e_bd);
  endtask

  initial begin
    bit hold;
    drive(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);

    //           iv    sel   d        ar    br    e_ir  e_av  e_ad     e_bv  e_bd
    tbl[0]  = '{1'b1, 1'b1, 16'h1111, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1111, 1'b0, 16'h0};
    tbl[1]  = '{1'b1, 1'b0, 16'h2222, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0,    1'b1, 16'h2222};
    tbl[2]  = '{1'b0, 1'b1, 16'h0,    1'b1, 1'b1, 1'b1, 1'b0, 16'h0,    1'b0, 16'h0};
    tbl[3]  = '{1'b1, 1'b1, 16'hA001, 1'b0, 1'b1, 1'b1, 1'b1, 16'hA001, 1'b0, 16'h0};
    tbl[4]  = '{1'b1, 1'b1, 16'hA002, 1'b0, 1'b1, 1'b1, 1'b1, 16'hA001, 1'b0, 16'h0};
    tbl[5]  = '{1'b1, 1'b1, 16'hA003, 1'b0, 1'b1, 1'b0, 1'b1, 16'hA001, 1'b0, 16'h0};
    tbl[6]  = '{1'b1, 1'b0, 16'hB00B, 1'b0, 1'b0, 1'b1, 1'b1, 16'hA001, 1'b1, 16'hB00B};
    tbl[7]  = '{1'b0, 1'b0, 16'h0,    1'b0, 1'b1, 1'b1, 1'b1, 16'hA001, 1'b0, 16'h0};
    tbl[8]  = '{1'b1, 1'b1, 16'hA003, 1'b1, 1'b1, 1'b0, 1'b1, 16'hA002, 1'b0, 16'h0};
    tbl[9]  = '{1'b1, 1'b1, 16'hA003, 1'b1, 1'b1, 1'b1, 1'b1, 16'hA003, 1'b0, 16'h0};
    tbl[10] = '{1'b0, 1'b1, 16'h0,    1'b1, 1'b1, 1'b1, 1'b0, 16'h0,    1'b0, 16'h0};
    tbl[11] = '{1'b1, 1'b1, 16'h0005, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0005, 1'b0, 16'h0};
    tbl[12] = '{1'b1, 1'b1, 16'h0006, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0006, 1'b0, 16'h0};
    tbl[13] = '{1'b0, 1'b1, 16'h0,    1'b1, 1'b1, 1'b1, 1'b0, 16'h0,    1'b0, 16'h0};

    do_reset("rst");
    for (int i = 0; i < 14; i++) step(tbl[i], i);

    // Back-to-back streaming into A: no bubbles, one-cycle latency.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 16'h3000 + 16'(i), 1'b1, 1'b1);
      #1 chkb("stream in_ready", bus.in_ready, 1'b1);
      @(posedge clk); #1;
      chkb("stream a_valid", bus.a_valid, 1'b1);
      chkw("stream a_data", bus.a_data, 16'h3000 + 16'(i));
    end

    // Random traffic against the queue model; a refused word is held.
    do_reset("rst2");
    hold = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!hold)
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
      else begin
        bus.a_ready = 1'($urandom_range(0, 1));
        bus.b_ready = 1'($urandom_range(0, 1));
      end
      #1;
      chkb("rnd in_ready", bus.in_ready,
           bus.select ? (qa.size() < 2) : (qb.size() < 2));
      hold = bus.in_valid && !bus.in_ready;
      @(posedge clk);
      model_edge();
      #1 check_model();
    end

    // Fill both buffers to TWO, then reset mid-flight.
    do_reset("rst3");
    step('{1'b1, 1'b1, 16'hA0A1, 1'b0, 1'b0, 1'b1, 1'b1, 16'hA0A1, 1'b0, 16'h0}, 100);
    step('{1'b1, 1'b1, 16'hA0A2, 1'b0, 1'b0, 1'b1, 1'b1, 16'hA0A1, 1'b0, 16'h0}, 101);
    step('{1'b1, 1'b0, 16'hB0B1, 1'b0, 1'b0, 1'b1, 1'b1, 16'hA0A1, 1'b1, 16'hB0B1}, 102);
    step('{1'b1, 1'b0, 16'hB0B2, 1'b0, 1'b0, 1'b1, 1'b1, 16'hA0A1, 1'b1, 16'hB0B1}, 103);
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
    #1 chkb("full A in_ready", bus.in_ready, 1'b0);
    bus.select = 1'b0;
    #1 chkb("full B in_ready", bus.in_ready, 1'b0);
    do_reset("midrst");

`ifdef DEMUX2_STREAM_COUNT_EN
    for (int i = 0; i < 65536; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 16'(i), 1'b1, 1'b1);
      @(posedge clk);
    end
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h0, 1'b1, 1'b1);
    #1 chkw("a_count max", a_count, 16'hFFFF);
    chkw("b_count idle", b_count, 16'h0);
    @(posedge clk); #1;
    chkw("a_count wrap", a_count, 16'h0);
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
